// File: rtl/phy_stim_sig_pkg.sv
// Shared constants, state encoding and LFSR/MISR step helper for phy_stim_sig.
package phy_stim_sig_pkg;

    localparam logic [31:0] POLY32     = 32'h0040_0007;

    localparam logic [1:0]  MODE_HOLD  = 2'd0;
    localparam logic [1:0]  MODE_SHIFT = 2'd1;
    localparam logic [1:0]  MODE_LFSR  = 2'd2;
    localparam logic [1:0]  MODE_COUNT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Left-shift Galois step for x^32+x^22+x^2+x+1
    function automatic logic [31:0] galois_step(input logic [31:0] v);
        galois_step = {v[30:0], 1'b0} ^ (v[31] ? POLY32 : 32'h0000_0000);
    endfunction

endpackage

// File: rtl/sig_misr32.sv
// Response fold (XOR of zero-padded 32-bit chunks) and 32-bit MISR register.
// Define PHY_STIM_SIG_MISR_EN for full MISR accumulation; otherwise the register just captures the fold.
module sig_misr32
    import phy_stim_sig_pkg::*;
#(
    parameter int IN_WIDTH = 80
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_clr,
    input  logic                i_en,
    input  logic [IN_WIDTH-1:0] i_resp,
    output logic [31:0]         o_misr_next
);

    localparam int NCHUNK = (IN_WIDTH + 31) / 32;

    logic [NCHUNK*32-1:0] w_pad;
    logic [31:0]          w_fold;
    logic [31:0]          w_step;
    logic [31:0]          w_misr_next;
    logic [31:0]          r_misr;

    // Zero-pad the response and XOR its chunks together
    always_comb begin
        w_pad                 = '0;
        w_pad[IN_WIDTH-1:0]   = i_resp;
        w_fold                = 32'h0000_0000;
        for (int k = 0; k < NCHUNK; k++) begin
            w_fold = w_fold ^ w_pad[k*32 +: 32];
        end
    end

    // Per-sample update: shifted MISR with feedback, or plain capture of the fold
    always_comb begin
`ifdef PHY_STIM_SIG_MISR_EN
        w_step = galois_step(r_misr) ^ w_fold;
`else
        w_step = w_fold;
`endif
    end

    // Clear wins over enable; the top samples this value on the final RUN cycle
    always_comb begin
        if (i_clr) begin
            w_misr_next = 32'h0000_0000;
        end else if (i_en) begin
            w_misr_next = w_step;
        end else begin
            w_misr_next = r_misr;
        end
    end

    // Signature register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misr <= 32'h0000_0000;
        end else begin
            r_misr <= w_misr_next;
        end
    end

    assign o_misr_next = w_misr_next;

endmodule

// File: rtl/phy_stim_sig.sv
// Stimulus generator (HOLD/SHIFT/LFSR/COUNT) and response compactor for phy_top wrappers.
// Optional macro PHY_STIM_SIG_MISR_EN selects full MISR accumulation in sig_misr32.
module phy_stim_sig
    import phy_stim_sig_pkg::*;
#(
    parameter int          OUT_WIDTH = 256,
    parameter int          IN_WIDTH  = 80,
    parameter int          WINDOW    = 16,
    parameter logic [31:0] SEED      = 32'h0000_0001
) (
    input  logic                 mclk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic                 ser_din,
    input  logic [IN_WIDTH-1:0]  resp,
    output logic [OUT_WIDTH-1:0] stim,
    output logic                 busy,
    output logic [31:0]          sig,
    output logic                 sig_valid
);

    localparam int               CNT_W    = $clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);
    localparam logic [31:0]      EFF_SEED = (SEED == 32'h0000_0000) ? 32'h0000_0001 : SEED;

    state_e                r_state;
    state_e                w_state_next;
    logic [1:0]            r_mode;
    logic [CNT_W-1:0]      r_cnt;
    logic [31:0]           r_lfsr;
    logic [OUT_WIDTH-1:0]  r_stim;
    logic [OUT_WIDTH-1:0]  w_stim_next;
    logic                  r_busy;
    logic [31:0]           r_sig;
    logic                  r_sig_valid;
    logic [31:0]           w_misr_next;
    logic                  w_start;
    logic                  w_run;
    logic                  w_last;

    assign w_start = (r_state == ST_IDLE) && start;
    assign w_run   = (r_state == ST_RUN);
    assign w_last  = w_run && (r_cnt == CNT_LAST);

    // State register
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; start outside IDLE is simply dropped
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Stimulus advance, only while running
    always_comb begin
        w_stim_next = r_stim;
        if (w_run) begin
            case (r_mode)
                MODE_SHIFT: w_stim_next = {r_stim[OUT_WIDTH-2:0], ser_din};
                MODE_LFSR:  w_stim_next = {r_stim[OUT_WIDTH-2:0], r_lfsr[31]};
                MODE_COUNT: w_stim_next = r_stim + OUT_WIDTH'(1);
                default:    w_stim_next = r_stim;
            endcase
        end else begin
            w_stim_next = r_stim;
        end
    end

    // Datapath registers; stim deliberately survives a new start
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode      <= MODE_HOLD;
            r_cnt       <= '0;
            r_lfsr      <= EFF_SEED;
            r_stim      <= '0;
            r_busy      <= 1'b0;
            r_sig       <= 32'h0000_0000;
            r_sig_valid <= 1'b0;
        end else begin
            r_stim      <= w_stim_next;
            r_busy      <= (w_state_next != ST_IDLE);
            r_sig_valid <= w_last;
            if (w_last) begin
                r_sig <= w_misr_next;
            end else begin
                r_sig <= r_sig;
            end
            if (w_start) begin
                r_mode <= mode;
                r_cnt  <= '0;
                r_lfsr <= EFF_SEED;
            end else if (w_run) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (r_mode == MODE_LFSR) begin
                    r_lfsr <= galois_step(r_lfsr);
                end else begin
                    r_lfsr <= r_lfsr;
                end
            end else begin
                r_cnt  <= r_cnt;
                r_lfsr <= r_lfsr;
            end
        end
    end

    sig_misr32 #(
        .IN_WIDTH (IN_WIDTH)
    ) u_misr (
        .clk         (mclk),
        .rst_n       (rst_n),
        .i_clr       (w_start),
        .i_en        (w_run),
        .i_resp      (resp),
        .o_misr_next (w_misr_next)
    );

    assign stim      = r_stim;
    assign busy      = r_busy;
    assign sig       = r_sig;
    assign sig_valid = r_sig_valid;

endmodule
